// File: rtl/stdp_synapse.sv
// ============================================================================
// stdp_synapse : pair-based STDP synapse with clamped 8-bit weight
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module stdp_synapse #(
   parameter logic [7:0] W_INIT = 8'd16,
   parameter logic [7:0] W_MAX  = 8'd255,
   parameter logic [7:0] W_MIN  = 8'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pre_spike,
   input  logic       post_spike,
   output logic [7:0] weight,
   output logic [7:0] syn_current,
   output logic       update_flag,
   output logic [3:0] time_diff
);

   logic [3:0] pre_age;
   logic [3:0] post_age;
   logic       pre_valid;
   logic       post_valid;

   logic       ltp;
   logic       ltd;
   logic [7:0] ltp_delta;
   logic [7:0] ltd_delta;
   logic [8:0] ltp_sum;
   logic [8:0] ltd_diff;
   logic [7:0] next_weight;

   function automatic logic [7:0] delta_of(input logic [3:0] k);
      logic [7:0] d;
      case (k)
         4'd1, 4'd2:               d = 8'd16;
         4'd3, 4'd4:               d = 8'd8;
         4'd5, 4'd6, 4'd7, 4'd8:   d = 8'd4;
         default:                  d = 8'd2;
      endcase
      return d;
   endfunction

   // Coincident spikes cancel each other: neither LTP nor LTD fires.
   always_comb begin
      ltp         = post_spike & ~pre_spike & pre_valid;
      ltd         = pre_spike & ~post_spike & post_valid;
      ltp_delta   = delta_of(pre_age);
      ltd_delta   = delta_of(post_age);
      ltp_sum     = {1'b0, weight} + {1'b0, ltp_delta};
      ltd_diff    = {1'b0, weight} - {1'b0, ltd_delta};
      next_weight = weight;
      if (ltp) begin
         next_weight = (ltp_sum > {1'b0, W_MAX}) ? W_MAX : ltp_sum[7:0];
      end else if (ltd) begin
         next_weight = (ltd_diff[8] || (ltd_diff[7:0] < W_MIN)) ? W_MIN : ltd_diff[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         weight      <= W_INIT;
         syn_current <= 8'd0;
         update_flag <= 1'b0;
         time_diff   <= 4'd0;
         pre_age     <= 4'd0;
         post_age    <= 4'd0;
         pre_valid   <= 1'b0;
         post_valid  <= 1'b0;
      end else if (ena) begin
         weight      <= next_weight;
         update_flag <= ltp | ltd;
         syn_current <= pre_spike ? weight : 8'd0;
         if (ltp) begin
            time_diff <= pre_age;
         end else if (ltd) begin
            time_diff <= post_age;
         end

         // A consumed trace is retired so each spike pairs at most once.
         if (pre_spike) begin
            pre_age   <= 4'd1;
            pre_valid <= 1'b1;
         end else if (pre_valid) begin
            if (ltp || (pre_age == 4'd15)) begin
               pre_valid <= 1'b0;
            end else begin
               pre_age <= pre_age + 4'd1;
            end
         end

         if (post_spike) begin
            post_age   <= 4'd1;
            post_valid <= 1'b1;
         end else if (post_valid) begin
            if (ltd || (post_age == 4'd15)) begin
               post_valid <= 1'b0;
            end else begin
               post_age <= post_age + 4'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stdp_synapse.sv
// ============================================================================
// tb_stdp_synapse : directed scoreboard bench for stdp_synapse
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stdp_synapse;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       pre_spike;
   logic       post_spike;
   logic [7:0] weight;
   logic [7:0] syn_current;
   logic       update_flag;
   logic [3:0] time_diff;

   int tests;
   int fails;

   typedef struct {
      logic [7:0] w;
      logic [7:0] sc;
      logic       f;
      logic [3:0] td;
   } exp_t;

   exp_t exp_q[$];

   // Behavioural reference state
   int m_w, m_sc, m_f, m_td;
   int m_pa, m_qa;
   bit m_pv, m_qv;

   stdp_synapse #(
      .W_INIT(8'd16),
      .W_MAX (8'd255),
      .W_MIN (8'd0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .weight     (weight),
      .syn_current(syn_current),
      .update_flag(update_flag),
      .time_diff  (time_diff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int delta(input int k);
      if (k <= 2)      return 16;
      else if (k <= 4) return 8;
      else if (k <= 8) return 4;
      else             return 2;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit pre, input bit post, input bit en, input bit rn);
      bit ltp, ltd;
      int nw;
      if (!rn) begin
         m_w = 16; m_sc = 0; m_f = 0; m_td = 0;
         m_pa = 0; m_qa = 0; m_pv = 0; m_qv = 0;
      end else if (en) begin
         ltp = post && !pre && m_pv;
         ltd = pre && !post && m_qv;
         nw  = m_w;
         if (ltp) nw = (m_w + delta(m_pa) > 255) ? 255 : m_w + delta(m_pa);
         if (ltd) nw = (m_w < delta(m_qa)) ? 0 : m_w - delta(m_qa);
         m_f  = (ltp || ltd) ? 1 : 0;
         if (ltp) m_td = m_pa;
         if (ltd) m_td = m_qa;
         m_sc = pre ? m_w : 0;
         m_w  = nw;
         if (pre) begin
            m_pa = 1; m_pv = 1;
         end else if (m_pv) begin
            if (ltp || m_pa == 15) m_pv = 0;
            else m_pa++;
         end
         if (post) begin
            m_qa = 1; m_qv = 1;
         end else if (m_qv) begin
            if (ltd || m_qa == 15) m_qv = 0;
            else m_qa++;
         end
      end
   endtask

   // Drive one clock cycle; expected outputs are queued, then checked after the edge.
   task automatic cyc(input bit pre, input bit post, input bit en = 1'b1, input bit rn = 1'b1);
      exp_t e;
      exp_t got;
      pre_spike  = pre;
      post_spike = post;
      ena        = en;
      rst_n      = rn;
      model(pre, post, en, rn);
      e.w  = 8'(m_w);
      e.sc = 8'(m_sc);
      e.f  = m_f[0];
      e.td = 4'(m_td);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("weight",      int'(weight),      int'(got.w));
      chk("syn_current", int'(syn_current), int'(got.sc));
      chk("update_flag", int'(update_flag), int'(got.f));
      chk("time_diff",   int'(time_diff),   int'(got.td));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
   endtask

   task automatic ltp_pair(input int k);
      cyc(1'b1, 1'b0);
      idle(k - 1);
      cyc(1'b0, 1'b1);
      idle(16);
   endtask

   task automatic ltd_pair(input int k);
      cyc(1'b0, 1'b1);
      idle(k - 1);
      cyc(1'b1, 1'b0);
      idle(16);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0; ena = 1'b1; pre_spike = 1'b0; post_spike = 1'b0;

      // Reset and quiet period
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset_weight", int'(weight), 16);
      chk("reset_td", int'(time_diff), 0);
      idle(20);
      chk("idle_weight", int'(weight), 16);

      // Pre then post two cycles later: LTP k=2
      cyc(1'b1, 1'b0);
      chk("ltp_syn_current", int'(syn_current), 16);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      chk("ltp_weight", int'(weight), 32);
      chk("ltp_flag", int'(update_flag), 1);
      chk("ltp_td", int'(time_diff), 2);
      idle(1);
      chk("ltp_flag_drop", int'(update_flag), 0);
      idle(16);

      // Post then pre six cycles later: LTD k=6
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      idle(5);
      cyc(1'b1, 1'b0);
      chk("ltd_weight", int'(weight), 12);
      chk("ltd_td", int'(time_diff), 6);
      idle(1);
      chk("ltd_flag_drop", int'(update_flag), 0);
      idle(16);

      // Expired trace, then coincident spikes, then pairing at k=15
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      idle(19);
      cyc(1'b0, 1'b1);
      chk("expired_weight", int'(weight), 16);
      chk("expired_flag", int'(update_flag), 0);
      idle(16);
      cyc(1'b1, 1'b1);
      chk("coincident_weight", int'(weight), 16);
      chk("coincident_flag", int'(update_flag), 0);
      idle(16);
      ltp_pair(15);
      chk("k15_weight", int'(weight), 18);

      // Upper clamp
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) ltp_pair(1);
      ltp_pair(3);
      chk("w248", int'(weight), 248);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("sat_hi_weight", int'(weight), 255);
      chk("sat_hi_flag", int'(update_flag), 1);
      idle(16);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("sat_hi_hold_flag", int'(update_flag), 1);
      idle(16);

      // Lower clamp
      for (int i = 0; i < 15; i++) ltd_pair(1);
      ltd_pair(3);
      ltd_pair(5);
      chk("w3", int'(weight), 3);
      cyc(1'b0, 1'b1);
      idle(2);
      cyc(1'b1, 1'b0);
      chk("sat_lo_weight", int'(weight), 0);
      chk("sat_lo_flag", int'(update_flag), 1);
      idle(16);
      ltd_pair(9);
      chk("sat_lo_hold", int'(weight), 0);

      // Reset between edges has no effect until the next edge
      rst_n = 1'b0;
      #2;
      chk("async_rst_ignored", int'(weight), 0);

      // Reset aborts a pending pairing
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ltp_pair(1);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("abort_weight", int'(weight), 16);
      chk("abort_flag", int'(update_flag), 0);
      idle(16);

      // ena=0 freezes everything, traces included
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("ena0_sc_hold", int'(syn_current), 16);
      chk("ena0_weight", int'(weight), 16);
      cyc(1'b0, 1'b1);
      chk("ena_resume_td", int'(time_diff), 1);
      chk("ena_resume_weight", int'(weight), 32);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
